// File: rtl/instr_fetch_responder_pkg.sv
// Shared widths, NOP encoding and FSM state encodings for the instruction fetch responder.
package instr_fetch_responder_pkg;
  localparam int          AddrWidth  = 32;
  localparam int          InstrWidth = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_responder_rom.sv
// Instruction storage: one synchronous write port for program load, one combinational read port.
module instr_fetch_rom
  import instr_fetch_responder_pkg::*;
#(
  parameter int INSTR_WIDTH = InstrWidth,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [IDX_W-1:0]       i_waddr,
  input  logic [INSTR_WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0]       i_raddr,
  output logic [INSTR_WIDTH-1:0] o_rdata
);
  logic [INSTR_WIDTH-1:0] r_mem [DEPTH_WORDS];

  // No reset: program contents survive reset by design.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instr_fetch_responder.sv
// Single-outstanding instruction fetch responder with fixed response latency and address checking.
module instr_fetch_responder
  import instr_fetch_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = AddrWidth,
  parameter int INSTR_WIDTH = InstrWidth,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  localparam int IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [ADDR_WIDTH-1:0]  i_req_addr,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [INSTR_WIDTH-1:0] o_rsp_data,
  output logic                   o_rsp_err,
  input  logic                   i_load_we,
  input  logic [IDX_W-1:0]       i_load_addr,
  input  logic [INSTR_WIDTH-1:0] i_load_data
);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  fetch_state_t           r_state, w_state_nxt;
  logic [3:0]             r_cnt, w_cnt_nxt;
  logic [INSTR_WIDTH-1:0] r_rsp_data;
  logic                   r_rsp_err;

  logic                   w_accept;
  logic [ADDR_WIDTH-1:0]  w_word_idx;
  logic                   w_misaligned;
  logic                   w_out_of_range;
  logic                   w_err;
  logic [INSTR_WIDTH-1:0] w_rom_rdata;

  assign w_accept       = i_req_valid && o_req_ready;
  // Full-width compare so high address bits cannot alias into the array.
  assign w_word_idx     = i_req_addr >> 2;
  assign w_misaligned   = (i_req_addr[1:0] != 2'b00);
  assign w_out_of_range = (w_word_idx >= ADDR_WIDTH'(DEPTH_WORDS));
  assign w_err          = w_misaligned || w_out_of_range;

  instr_fetch_rom #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_rom (
    .clk     (clk),
    .i_we    (i_load_we),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_raddr (i_req_addr[IDX_W+1:2]),
    .o_rdata (w_rom_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (LATENCY <= 1) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = ST_RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      ST_RESP: begin
        if (i_rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Response is captured at accept, so later loads cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rsp_err  <= w_err;
        r_rsp_data <= w_err ? INSTR_WIDTH'(NOP_INSTR) : w_rom_rdata;
      end
    end
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench: three responders (LATENCY 1, 2, 4) share stimulus; each phase checks one of them.
module tb_instr_fetch_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        load_we;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  logic        rdy1, vld1, err1, rdy2, vld2, err2, rdy4, vld4, err4;
  logic [31:0] dat1, dat2, dat4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .i_req_valid(req_valid), .o_req_ready(rdy1), .i_req_addr(req_addr),
    .o_rsp_valid(vld1), .i_rsp_ready(rsp_ready), .o_rsp_data(dat1), .o_rsp_err(err1),
    .i_load_we(load_we), .i_load_addr(load_addr), .i_load_data(load_data));
  instr_fetch_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .i_req_valid(req_valid), .o_req_ready(rdy2), .i_req_addr(req_addr),
    .o_rsp_valid(vld2), .i_rsp_ready(rsp_ready), .o_rsp_data(dat2), .o_rsp_err(err2),
    .i_load_we(load_we), .i_load_addr(load_addr), .i_load_data(load_data));
  instr_fetch_responder #(.LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .i_req_valid(req_valid), .o_req_ready(rdy4), .i_req_addr(req_addr),
    .o_rsp_valid(vld4), .i_rsp_ready(rsp_ready), .o_rsp_data(dat4), .o_rsp_err(err4),
    .i_load_we(load_we), .i_load_addr(load_addr), .i_load_data(load_data));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [7:0] idx, input logic [31:0] d);
    load_we = 1'b1; load_addr = idx; load_data = d;
    tick();
    load_we = 1'b0;
  endtask

  // LATENCY=2 fetch with rsp_ready held high: accept, wait, respond, back to idle.
  task automatic fetch2(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                        input logic exp_e);
    req_valid = 1'b1; req_addr = a;
    chk({tag, "_rdy"}, {31'd0, rdy2}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk({tag, "_t1_vld"}, {31'd0, vld2}, 32'd0);
    tick();
    chk({tag, "_vld"}, {31'd0, vld2}, 32'd1);
    chk({tag, "_data"}, dat2, exp_d);
    chk({tag, "_err"}, {31'd0, err2}, {31'd0, exp_e});
    tick();
    chk({tag, "_idle"}, {31'd0, rdy2}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    load_we = 1'b0; load_addr = '0; load_data = '0;

    // Program load while reset is held.
    load(8'd0,   32'h11111111);
    load(8'd1,   32'h00500093);
    load(8'd2,   32'h22222222);
    load(8'd3,   32'h00000013);
    load(8'd255, 32'hCAFEF00D);
    chk("rst_vld", {31'd0, vld2}, 32'd0);
    chk("rst_data", dat2, 32'd0);
    chk("rst_err", {31'd0, err2}, 32'd0);
    reset = 1'b0;
    chk("rst_rdy", {31'd0, rdy2}, 32'd1);

    // Basic fetch and address checks.
    fetch2("word1", 32'h4, 32'h00500093, 1'b0);
    fetch2("misalign", 32'h6, 32'h00000013, 1'b1);
    fetch2("oor", 32'h400, 32'h00000013, 1'b1);
    fetch2("last", 32'h3FC, 32'hCAFEF00D, 1'b0);
    fetch2("highbit", 32'h80000004, 32'h00000013, 1'b1);
    fetch2("word2", 32'h8, 32'h22222222, 1'b0);

    // Backpressure: hold 5 cycles, ignored request and load during hold.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_addr = 32'h8;
    tick();
    load_we = 1'b1; load_addr = 8'd1; load_data = 32'hAAAAAAAA;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", {31'd0, vld2}, 32'd1);
      chk("bp_data", dat2, 32'h00500093);
      chk("bp_err", {31'd0, err2}, 32'd0);
      chk("bp_rdy", {31'd0, rdy2}, 32'd0);
      tick();
      load_we = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_vld", {31'd0, vld2}, 32'd0);
    chk("bp_release_rdy", {31'd0, rdy2}, 32'd1);
    tick();
    req_valid = 1'b0;
    tick();
    chk("bp_next_vld", {31'd0, vld2}, 32'd1);
    chk("bp_next_data", dat2, 32'h22222222);
    tick();

    // Same-cycle load and fetch of index 3: old word returned first.
    req_valid = 1'b1; req_addr = 32'hC;
    load_we = 1'b1; load_addr = 8'd3; load_data = 32'hDEADBEEF;
    tick();
    req_valid = 1'b0; load_we = 1'b0;
    tick();
    chk("rbw_vld", {31'd0, vld2}, 32'd1);
    chk("rbw_old", dat2, 32'h00000013);
    tick();
    fetch2("rbw_new", 32'hC, 32'hDEADBEEF, 1'b0);

    // LATENCY=4: reset one cycle after accept drops the request.
    do_reset();
    req_valid = 1'b1; req_addr = 32'h8;
    chk("l4_rdy", {31'd0, rdy4}, 32'd1);
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("l4_rst_rdy", {31'd0, rdy4}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("l4_dropped_vld", {31'd0, vld4}, 32'd0);
      tick();
    end
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk("l4_t3_vld", {31'd0, vld4}, 32'd0);
    tick();
    chk("l4_t4_vld", {31'd0, vld4}, 32'd1);
    chk("l4_data", dat4, 32'h22222222);
    chk("l4_err", {31'd0, err4}, 32'd0);
    tick();

    // LATENCY=1 back-to-back: accept every 2 cycles, response 1 cycle after accept.
    do_reset();
    req_valid = 1'b1; req_addr = 32'h0;
    chk("l1_rdy0", {31'd0, rdy1}, 32'd1);
    tick();
    req_addr = 32'h4;
    chk("l1_vld0", {31'd0, vld1}, 32'd1);
    chk("l1_data0", dat1, 32'h11111111);
    chk("l1_busy0", {31'd0, rdy1}, 32'd0);
    tick();
    chk("l1_gap0", {31'd0, vld1}, 32'd0);
    chk("l1_rdy1", {31'd0, rdy1}, 32'd1);
    tick();
    req_addr = 32'h8;
    chk("l1_vld1", {31'd0, vld1}, 32'd1);
    chk("l1_data1", dat1, 32'hAAAAAAAA);
    tick();
    chk("l1_rdy2", {31'd0, rdy1}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("l1_vld2", {31'd0, vld1}, 32'd1);
    chk("l1_data2", dat1, 32'h22222222);
    chk("l1_err2", {31'd0, err1}, 32'd0);
    tick();
    chk("l1_idle", {31'd0, rdy1}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
